// File: rtl/ysyx_22050535_mdu.sv
// Iterative RV32M/RV64M multiply/divide unit with valid/ready handshakes.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, func3, src1, src2,
//        tag_in (request side); flush (abort); out_valid/out_ready, result,
//        tag_out (response side); busy (BUSY or DONE).
module ysyx_22050535_mdu #(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 5,
    parameter int MUL_FAST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       func3,
    input  logic [XLEN-1:0]  src1,
    input  logic [XLEN-1:0]  src2,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out,
    output logic             busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic                fast_q, fast_d;
    logic                qneg_q, qneg_d;
    logic                rneg_q, rneg_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [TAG_W-1:0]    tag_out_q, tag_out_d;

    // ---------------- request decode ----------------
    logic              is_div_in;
    logic              s1_signed, s2_signed;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, fast_in;
    logic [2*XLEN-1:0] prod_raw, prod_fix;
    logic [XLEN-1:0]   fast_res;

    always_comb begin
        is_div_in = func3[2];
        // MULH/MULHSU treat src1 as signed; only MULH treats src2 as signed.
        s1_signed = is_div_in ? ~func3[0] : (func3[1] ^ func3[0]);
        s2_signed = is_div_in ? ~func3[0] : (func3[1:0] == 2'b01);
        a_neg     = s1_signed & src1[XLEN-1];
        b_neg     = s2_signed & src2[XLEN-1];
        a_mag     = a_neg ? -src1 : src1;
        b_mag     = b_neg ? -src2 : src2;
        div_zero  = (src2 == '0);
        div_ovf   = ~func3[0] & (src1 == MIN_NEG) & (&src2);
        fast_in   = is_div_in ? (div_zero | div_ovf) : (MUL_FAST != 0);
        prod_raw  = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
        prod_fix  = (a_neg ^ b_neg) ? -prod_raw : prod_raw;
        fast_res  = '0;
        if (is_div_in) begin
            if (div_zero)
                fast_res = func3[1] ? src1 : '1;
            else
                fast_res = func3[1] ? '0 : src1;
        end else if (MUL_FAST != 0) begin
            fast_res = (func3[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                             : prod_fix[2*XLEN-1:XLEN];
        end
    end

    // ---------------- one iteration step ----------------
    // acc holds {partial_hi, multiplier} for multiply (shift right)
    // and {remainder, dividend/quotient} for divide (shift left).
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_r, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] step_next, prod_fin;
    logic [XLEN-1:0]   quo, rem, final_res;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]}
                 + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_r    = acc_q[2*XLEN-1:XLEN-1];
        div_diff = div_r - {1'b0, opnd_q};
        div_ge   = ~div_diff[XLEN];
        if (op_q[2])
            step_next = {div_ge ? div_diff[XLEN-1:0] : div_r[XLEN-1:0],
                         acc_q[XLEN-2:0], div_ge};
        else
            step_next = {mul_sum, acc_q[XLEN-1:1]};

        prod_fin = qneg_q ? -step_next : step_next;
        quo      = step_next[XLEN-1:0];
        rem      = step_next[2*XLEN-1:XLEN];
        if (op_q[2]) begin
            if (op_q[1])
                final_res = rneg_q ? -rem : rem;
            else
                final_res = qneg_q ? -quo : quo;
        end else begin
            final_res = (op_q[1:0] == 2'b00) ? prod_fin[XLEN-1:0]
                                             : prod_fin[2*XLEN-1:XLEN];
        end
    end

    // ---------------- control ----------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        tag_d     = tag_q;
        fast_d    = fast_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        result_d  = result_q;
        tag_out_d = tag_out_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_BUSY;
                    cnt_d   = '0;
                    op_d    = func3;
                    tag_d   = tag_in;
                    fast_d  = fast_in;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    opnd_d  = is_div_in ? b_mag : a_mag;
                    if (fast_in)
                        acc_d = {{XLEN{1'b0}}, fast_res};
                    else
                        acc_d = {{XLEN{1'b0}}, is_div_in ? a_mag : b_mag};
                end
            end
            S_BUSY: begin
                // Fast ops resolve at accept and spend one cycle here.
                if (fast_q) begin
                    result_d  = acc_q[XLEN-1:0];
                    tag_out_d = tag_q;
                    state_d   = S_DONE;
                end else begin
                    acc_d = step_next;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN-1)) begin
                        result_d  = final_res;
                        tag_out_d = tag_q;
                        state_d   = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort keeps the last delivered result/tag untouched.
        if (flush) begin
            state_d   = S_IDLE;
            result_d  = result_q;
            tag_out_d = tag_out_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            tag_q     <= '0;
            fast_q    <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            tag_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            fast_q    <= fast_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            tag_out_q <= tag_out_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign tag_out   = tag_out_q;

endmodule

// File: tb/tb_ysyx_22050535_mdu.sv
// Self-checking bench for ysyx_22050535_mdu (XLEN=32, MUL_FAST=0).
// Directed ops with literal expectations plus a model-fed scoreboard.
module tb_ysyx_22050535_mdu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  func3 = '0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic [4:0]  tag_in = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [4:0]  tag_out;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_res_q[$];
    logic [4:0]  exp_tag_q[$];

    ysyx_22050535_mdu #(
        .XLEN(32),
        .TAG_W(5),
        .MUL_FAST(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .func3(func3),
        .src1(src1),
        .src2(src2),
        .tag_in(tag_in),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .tag_out(tag_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // RISC-V M semantics straight from the ISA definition.
    function automatic logic [31:0] model(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Scoreboard: predict on accept, check every valid cycle, pop on handshake.
    always @(negedge clk) begin
        if (rst || flush) begin
            exp_res_q.delete();
            exp_tag_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_res_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: out_valid=1 result=%0h expected no output",
                             result);
                end else begin
                    chk("sb_result", {32'b0, result}, {32'b0, exp_res_q[0]});
                    chk("sb_tag", {59'b0, tag_out}, {59'b0, exp_tag_q[0]});
                    if (out_ready) begin
                        void'(exp_res_q.pop_front());
                        void'(exp_tag_q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_res_q.push_back(model(func3, src1, src2));
                exp_tag_q.push_back(tag_in);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] t);
        chk("in_ready_before_op", {63'b0, in_ready}, 64'd1);
        func3    = f;
        src1     = a;
        src2     = b;
        tag_in   = t;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] t,
                         input logic [31:0] exp_res, input int exp_lat,
                         input int hold);
        int n;
        accept(f, a, b, t);
        n = 0;
        while (n < 200) begin
            step();
            n++;
            if (out_valid) break;
        end
        chk("latency", 64'(n), 64'(exp_lat));
        chk("result", {32'b0, result}, {32'b0, exp_res});
        chk("tag_out", {59'b0, tag_out}, {59'b0, t});
        for (int i = 0; i < hold; i++) begin
            step();
            chk("bp_valid", {63'b0, out_valid}, 64'd1);
            chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
            chk("bp_result", {32'b0, result}, {32'b0, exp_res});
            chk("bp_tag", {59'b0, tag_out}, {59'b0, t});
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("after_hs_valid", {63'b0, out_valid}, 64'd0);
        chk("after_hs_ready", {63'b0, in_ready}, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  n;
        logic seen;

        // Pin the model to hand-computed values.
        chk("model_mul", {32'b0, model(3'd0, 32'd7, 32'hFFFF_FFFD)}, 64'hFFFF_FFEB);
        chk("model_mulhsu", {32'b0, model(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF)},
            64'hFFFF_FFFF);
        chk("model_rem", {32'b0, model(3'd6, 32'hFFFF_FFF9, 32'd2)}, 64'hFFFF_FFFF);
        chk("model_div_ovf", {32'b0, model(3'd4, 32'h8000_0000, 32'hFFFF_FFFF)},
            64'h8000_0000);

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_result", {32'b0, result}, 64'd0);
        chk("rst_tag", {59'b0, tag_out}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);

        do_op(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 32, 0);
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, 32, 0);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 32, 0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 32, 0);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD, 32, 0);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF, 32, 0);
        do_op(3'd5, 32'd100,       32'd7,         5'd7,  32'd14,        32, 0);
        do_op(3'd7, 32'd100,       32'd7,         5'd8,  32'd2,         32, 0);
        do_op(3'd4, 32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF, 1,  0);
        do_op(3'd7, 32'd5,         32'd0,         5'd10, 32'd5,         1,  0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1,  0);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,         1,  0);
        do_op(3'd5, 32'd50,        32'd5,         5'd13, 32'd10,        32, 5);

        // The next accept is possible right after the handshake cycle.
        accept(3'd5, 32'd81, 32'd9, 5'd14);
        chk("accept_after_bp", {63'b0, busy}, 64'd1);
        n = 0;
        while (n < 200 && !out_valid) begin
            step();
            n++;
        end
        chk("bp_next_lat", 64'(n), 64'd32);
        chk("bp_next_res", {32'b0, result}, 64'd9);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Flush part-way through: no output, last result retained.
        accept(3'd5, 32'd1000, 32'd7, 5'd20);
        for (int i = 0; i < 9; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_valid", {63'b0, out_valid}, 64'd0);
        chk("flush_in_ready", {63'b0, in_ready}, 64'd1);
        chk("flush_busy", {63'b0, busy}, 64'd0);
        chk("flush_keeps_result", {32'b0, result}, 64'd9);
        chk("flush_keeps_tag", {59'b0, tag_out}, 64'd14);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            seen = seen | out_valid;
        end
        chk("flush_no_output", {63'b0, seen}, 64'd0);

        // Reset part-way through: everything back to reset values.
        accept(3'd0, 32'd3, 32'd5, 5'd21);
        for (int i = 0; i < 19; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_valid", {63'b0, out_valid}, 64'd0);
        chk("rst2_result", {32'b0, result}, 64'd0);
        chk("rst2_tag", {59'b0, tag_out}, 64'd0);
        chk("rst2_busy", {63'b0, busy}, 64'd0);
        chk("rst2_in_ready", {63'b0, in_ready}, 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            seen = seen | out_valid;
        end
        chk("rst2_no_output", {63'b0, seen}, 64'd0);

        do_op(3'd5, 32'd9, 32'd3, 5'd22, 32'd3, 32, 0);

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
